ex_result_stage: RTL and testbench
==================================

# ex_result_stage

Pipeline stage directly downstream of the 16-bit ALU. It captures each ALU result together with its NZCV flags, destination register and write-enable. It holds the architectural flags register and buffers results in a 2-entry queue toward the register-file writeback port using valid/ready handshakes. CMP results update flags only and never write a register.

## Interface
Parameters:
- WORD_W, 16, datapath width (matches ALU word size)
- RD_W, 4, destination register address width
- DEPTH, 2, result queue depth (fixed at 2; other values unsupported)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ALU result present this cycle
- in_ready  output  1  stage can accept; driven from registered occupancy only
- in_op  input  5  ALU opcode of the result (01111 = CMP)
- in_result  input  WORD_W  ALU result
- in_nzcv  input  4  ALU flags, bit3=N, bit2=Z, bit1=C, bit0=V
- in_rd  input  RD_W  destination register
- in_wb_en  input  1  instruction writes in_rd
- in_set_flags  input  1  instruction updates flags
- flush  input  1  discard all queued results (pipeline redirect)
- out_valid  output  1  queue head valid
- out_ready  input  1  writeback accepts head
- out_data  output  WORD_W  head result
- out_rd  output  RD_W  head destination
- out_wb_en  output  1  head write-enable
- flags  output  4  architectural NZCV register

## Operation
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- On accept, push {in_result, in_rd, wb_en_eff}. wb_en_eff = in_wb_en && (in_op != 01111).
- On accept, the flags register updates as follows:
  - If in_set_flags or in_op == 01111, flags <= in_nzcv.
  - Otherwise flags holds.
- CMP always updates flags, regardless of in_set_flags.
- Occupancy count takes values 0..2. in_ready = (count != 2). out_valid = (count != 0).
- Queue is FIFO-ordered. Heads are presented in acceptance order.
- Accept and pop in the same cycle: count unchanged, throughput 1 result/cycle.
- Accept while full: impossible, because in_ready = 0. in_valid is ignored.
- Pop while empty: impossible, because out_valid = 0. out_ready is ignored.
- Upstream holds in_* stable while in_valid && !in_ready. The stage does not require this, since it samples only on accept.
- flush: count <= 0 and read/write pointers reset next edge.
  - flush wins over a simultaneous accept: the entry is dropped, but flags still update from that accept.
  - flush wins over a simultaneous pop: the pop completes from the downstream view and the queue is empty next cycle.
- rst has priority over flush and all handshakes.
- Reset values: count 0, pointers 0, flags 4'b0000, out_valid 0, out_data/out_rd/out_wb_en 0, in_ready 0.
- in_ready goes to 1 on the first cycle after rst deasserts.
- rst mid-stream discards all queued entries. No partial writeback.

## Timing
- Latency: accept at edge N; out_valid and head data visible after edge N (cycle N+1) when the queue was empty.
- flags reflect an accepted instruction from cycle N+1, independent of writeback progress.
- No combinational path from out_ready to in_ready. in_ready depends only on the registered count.
- Paths exist from in_* to storage only. out_* are driven from queue registers, with the head muxed by the read pointer.
- Backpressure: with out_ready held low, two accepts fill the queue; in_ready falls in the cycle after the second accept.

## Structure
- Shared package alu_pkg holds:
  - the WORD_W constant (16)
  - the 5-bit opcode constants, including OP_CMP = 5'b01111
  - NZCV bit-index constants N=3, Z=2, C=1, V=0
- ALU and this stage both import alu_pkg.
- One sub-module: result_fifo2 (2-entry register FIFO with count, push/pop/flush).
- Flag register and wb_en_eff logic live in ex_result_stage.

## Test plan
- Reset then single ADD: in_result 0x1234, rd 3, wb_en 1, set_flags 1, nzcv 0000 -> next cycle out_valid 1, out_data 0x1234, out_rd 3, flags 0000; pop empties the queue.
- CMP: in_op 01111, wb_en 1, set_flags 0, nzcv 0100 -> flags 0100 next cycle, out_wb_en 0.
- Backpressure: out_ready 0, accept 0x0001 then 0x0002 -> in_ready 0; third in_valid ignored. Release out_ready -> 0x0001 then 0x0002 in order.
- Streaming: in_valid and out_ready both held 1 for 8 results 0x0010..0x0017 -> 8 consecutive out_valid cycles, in order, in_ready never drops.
- Flush with simultaneous accept while count 1: entry 0x00AA, nzcv 1000, set_flags 1 -> next cycle out_valid 0, count 0, flags 1000.
- rst asserted with queue full -> next cycle out_valid 0, flags 0000, in_ready 0. One cycle after deassert, in_ready 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and the result stage: datapath widths,
// opcode encodings and NZCV flag bit positions.
package alu_pkg;

    localparam int WORD_W = 16;
    localparam int RD_W   = 4;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_CMP = 5'b01111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // CMP computes flags only; it never produces a register write.
    function automatic logic is_cmp(input logic [4:0] op);
        return op == OP_CMP;
    endfunction

endpackage

// File: rtl/ex_result_stage_if.sv
// Bus between the ALU, the result stage and the register-file writeback
// port. The slave modport is the stage's view; master is the environment.
interface ex_result_stage_if
    import alu_pkg::*;
#(
    parameter int WORD_W = alu_pkg::WORD_W,
    parameter int RD_W   = alu_pkg::RD_W
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [WORD_W-1:0] in_result;
    logic [3:0]        in_nzcv;
    logic [RD_W-1:0]   in_rd;
    logic              in_wb_en;
    logic              in_set_flags;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_wb_en;
    logic [3:0]        flags;

    modport slave (
        input  in_valid, in_op, in_result, in_nzcv, in_rd, in_wb_en,
               in_set_flags, flush, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_wb_en, flags
    );

    modport master (
        output in_valid, in_op, in_result, in_nzcv, in_rd, in_wb_en,
               in_set_flags, flush, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_wb_en, flags
    );

endinterface

// File: rtl/result_fifo2.sv
// Two-entry register FIFO with occupancy count and flush. Ready depends
// only on registered state, so there is no path from pop_ready to push_ready.
module result_fifo2 #(
    parameter int W     = 21,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [2];
    logic             wptr;
    logic             rptr;
    logic [CNT_W-1:0] count;
    logic             live;
    logic             push;
    logic             pop;

    // live holds push_ready low while in reset and for the reset edge itself.
    assign push_ready = live && (count != CNT_W'(DEPTH));
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rptr];
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;

    // Storage, pointers and count; flush drops everything, including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            live   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                count <= '0;
                wptr  <= 1'b0;
                rptr  <= 1'b0;
            end else begin
                if (push) begin
                    mem[wptr] <= push_data;
                    wptr      <= ~wptr;
                end
                if (pop) begin
                    rptr <= ~rptr;
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// Result stage after the ALU: owns the architectural NZCV register and
// queues results toward register-file writeback.
module ex_result_stage
    import alu_pkg::*;
#(
    parameter int WORD_W = alu_pkg::WORD_W,
    parameter int RD_W   = alu_pkg::RD_W,
    parameter int DEPTH  = 2
) (
    input logic              clk,
    input logic              rst,
    ex_result_stage_if.slave bus
);
    localparam int ENTRY_W = WORD_W + RD_W + 1;

    logic               accept;
    logic               wb_en_eff;
    logic               in_ready_w;
    logic               out_valid_w;
    logic [ENTRY_W-1:0] head;
    logic [3:0]         flags_q;

    assign accept    = bus.in_valid && in_ready_w;
    assign wb_en_eff = bus.in_wb_en && !is_cmp(bus.in_op);

    // Flags follow every accepted flag-setting op or CMP, even when a flush drops the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (accept && (bus.in_set_flags || is_cmp(bus.in_op))) begin
            flags_q <= bus.in_nzcv;
        end
    end

    result_fifo2 #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.flush),
        .push_valid (bus.in_valid),
        .push_ready (in_ready_w),
        .push_data  ({bus.in_result, bus.in_rd, wb_en_eff}),
        .pop_valid  (out_valid_w),
        .pop_ready  (bus.out_ready),
        .pop_data   (head)
    );

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = head[ENTRY_W-1 -: WORD_W];
    assign bus.out_rd    = head[RD_W:1];
    assign bus.out_wb_en = head[0];
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_ex_result_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ex_result_stage_if #(.WORD_W(16), .RD_W(4)) bus ();

    ex_result_stage #(.WORD_W(16), .RD_W(4), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [15:0] res,
                         input logic [3:0] rd, input logic wb, input logic sf,
                         input logic [3:0] nzcv);
        bus.in_valid     = v;
        bus.in_op        = op;
        bus.in_result    = res;
        bus.in_rd        = rd;
        bus.in_wb_en     = wb;
        bus.in_set_flags = sf;
        bus.in_nzcv      = nzcv;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        idle();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_flags",     32'(bus.flags),     32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        chk("rst_out_rd",    32'(bus.out_rd),    32'h0);
        chk("rst_out_wb_en", 32'(bus.out_wb_en), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // single ADD
        drive(1'b1, OP_ADD, 16'h1234, 4'd3, 1'b1, 1'b1, 4'b0000);
        tick();
        idle();
        chk("add_out_valid", 32'(bus.out_valid), 32'd1);
        chk("add_out_data",  32'(bus.out_data),  32'h1234);
        chk("add_out_rd",    32'(bus.out_rd),    32'd3);
        chk("add_out_wb_en", 32'(bus.out_wb_en), 32'd1);
        chk("add_flags",     32'(bus.flags),     32'h0);
        pop_one();
        chk("add_popped", 32'(bus.out_valid), 32'd0);

        // CMP writes flags even without set_flags, never writes a register
        drive(1'b1, OP_CMP, 16'h0005, 4'd7, 1'b1, 1'b0, 4'b0100);
        tick();
        idle();
        chk("cmp_flags",     32'(bus.flags),     32'h4);
        chk("cmp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("cmp_out_wb_en", 32'(bus.out_wb_en), 32'd0);
        chk("cmp_out_rd",    32'(bus.out_rd),    32'd7);
        pop_one();

        // non flag-setting op leaves flags alone
        drive(1'b1, OP_SUB, 16'h0009, 4'd2, 1'b1, 1'b0, 4'b1111);
        tick();
        idle();
        chk("nosf_flags", 32'(bus.flags),     32'h4);
        chk("nosf_wb_en", 32'(bus.out_wb_en), 32'd1);
        pop_one();

        // backpressure
        drive(1'b1, OP_ADD, 16'h0001, 4'd1, 1'b1, 1'b0, 4'h0);
        tick();
        chk("bp_ready_1", 32'(bus.in_ready), 32'd1);
        drive(1'b1, OP_ADD, 16'h0002, 4'd2, 1'b1, 1'b0, 4'h0);
        tick();
        chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_head",       32'(bus.out_data), 32'h0001);
        drive(1'b1, OP_ADD, 16'h0003, 4'd3, 1'b1, 1'b0, 4'h0);
        tick();
        tick();
        idle();
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_head_kept",  32'(bus.out_data), 32'h0001);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_second",       32'(bus.out_data),  32'h0002);
        chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_ready_again",  32'(bus.in_ready),  32'd1);
        tick();
        bus.out_ready = 1'b0;
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // streaming at one result per cycle
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, OP_ADD, 16'h0010 + 16'(i), 4'(i), 1'b1, 1'b0, 4'h0);
            tick();
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_data",  32'(bus.out_data),  32'h10 + 32'(i));
            chk("stream_ready", 32'(bus.in_ready),  32'd1);
        end
        idle();
        tick();
        bus.out_ready = 1'b0;
        chk("stream_empty", 32'(bus.out_valid), 32'd0);

        // flush with simultaneous accept while one entry is queued
        drive(1'b1, OP_ADD, 16'h0050, 4'd5, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b1, OP_ADD, 16'h00AA, 4'd6, 1'b1, 1'b1, 4'b1000);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle();
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_flags",     32'(bus.flags),     32'h8);
        chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
        drive(1'b1, OP_ADD, 16'h00BB, 4'd4, 1'b1, 1'b0, 4'h0);
        tick();
        idle();
        chk("post_flush_data", 32'(bus.out_data), 32'h00BB);
        // flush with simultaneous pop
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_pop_empty", 32'(bus.out_valid), 32'd0);

        // reset with the queue full
        drive(1'b1, OP_ADD, 16'h0001, 4'd1, 1'b1, 1'b1, 4'b0011);
        tick();
        drive(1'b1, OP_ADD, 16'h0002, 4'd2, 1'b1, 1'b1, 4'b0011);
        tick();
        idle();
        chk("full_flags",    32'(bus.flags),    32'h3);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_flags",     32'(bus.flags),     32'h0);
        chk("rst2_in_ready",  32'(bus.in_ready),  32'd0);
        rst = 1'b0;
        tick();
        chk("rst2_ready_after", 32'(bus.in_ready),  32'd1);
        chk("rst2_still_empty", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
